// File: rtl/mem_burst_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the mem_burst arbiter.
//   arb_state_t : arbiter FSM states (IDLE / BUSY / REST)
//   OP_WR/OP_RD : operation bit of a source index (source = 2*channel + op)
//   LEN_BITS    : burst length width used by mem_burst
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_REST = 2'd2
    } arb_state_t;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

    localparam int LEN_BITS = 10;

endpackage

// File: rtl/mem_burst_arbiter_if.sv
// mem_burst_arbiter_if: the burst port between the arbiter and mem_burst.
//   master : arbiter side (drives requests, lengths, addresses, write data)
//   slave  : mem_burst side (drives data strobes, read data, finish pulses)
interface mem_burst_arbiter_if #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24
);
    import mem_arb_pkg::*;

    logic                     rd_burst_req;
    logic                     wr_burst_req;
    logic [LEN_BITS-1:0]      rd_burst_len;
    logic [LEN_BITS-1:0]      wr_burst_len;
    logic [ADDR_BITS-1:0]     rd_burst_addr;
    logic [ADDR_BITS-1:0]     wr_burst_addr;
    logic [MEM_DATA_BITS-1:0] wr_burst_data;
    logic                     wr_burst_data_req;
    logic [MEM_DATA_BITS-1:0] rd_burst_data;
    logic                     rd_burst_data_valid;
    logic                     rd_burst_finish;
    logic                     wr_burst_finish;

    modport master (
        output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
               rd_burst_addr, wr_burst_addr, wr_burst_data,
        input  wr_burst_data_req, rd_burst_data, rd_burst_data_valid,
               rd_burst_finish, wr_burst_finish
    );

    modport slave (
        input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
               rd_burst_addr, wr_burst_addr, wr_burst_data,
        output wr_burst_data_req, rd_burst_data, rd_burst_data_valid,
               rd_burst_finish, wr_burst_finish
    );

endinterface

// File: rtl/mem_burst_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req : N request bits
//   ptr : index where the search starts (wraps past N-1 to 0)
//   vld : at least one request is set
//   idx : first requesting index at or after ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        int            s;
        logic [IW-1:0] si;
        vld = 1'b0;
        idx = '0;
        s   = 0;
        si  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= N) s = s - N;
            si = IW'(s);
            if (req[si]) begin
                vld = 1'b1;
                idx = si;
            end
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: shares one mem_burst port among CH_NUM channels, each with
// an independent read and write request. One burst at a time, round-robin over
// sources s = 2*ch + op (op 0 = write, 1 = read).
//   mem_clk, rst            : clock, async active-high reset
//   init_calib_complete     : no grant while low
//   ch_rd_req / ch_wr_req   : per-channel level requests, held until finish
//   ch_*_len / ch_*_addr    : per-channel packed length / start address
//   ch_wr_data              : per-channel write data
//   ch_wr_data_req          : write strobe to the granted channel
//   ch_rd_data(_valid)      : shared read data, valid to granted channel only
//   ch_rd_finish/wr_finish  : one-cycle burst-done pulses
//   busy                    : arbiter not idle
//   mb                      : burst port toward mem_burst
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24,
    parameter int CH_NUM        = 2
) (
    input  logic                            mem_clk,
    input  logic                            rst,
    input  logic                            init_calib_complete,
    input  logic [CH_NUM-1:0]               ch_rd_req,
    input  logic [CH_NUM-1:0]               ch_wr_req,
    input  logic [CH_NUM*LEN_BITS-1:0]      ch_rd_len,
    input  logic [CH_NUM*LEN_BITS-1:0]      ch_wr_len,
    input  logic [CH_NUM*ADDR_BITS-1:0]     ch_rd_addr,
    input  logic [CH_NUM*ADDR_BITS-1:0]     ch_wr_addr,
    input  logic [CH_NUM*MEM_DATA_BITS-1:0] ch_wr_data,
    output logic [CH_NUM-1:0]               ch_wr_data_req,
    output logic [MEM_DATA_BITS-1:0]        ch_rd_data,
    output logic [CH_NUM-1:0]               ch_rd_data_valid,
    output logic [CH_NUM-1:0]               ch_rd_finish,
    output logic [CH_NUM-1:0]               ch_wr_finish,
    output logic                            busy,
    mem_burst_arbiter_if.master             mb
);

    localparam int NSRC = 2 * CH_NUM;
    localparam int IW   = $clog2(NSRC);
    localparam int CW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    arb_state_t           state, state_d;
    logic [IW-1:0]        ptr, pick_idx, gnt_src;
    logic [NSRC-1:0]      src_req;
    logic                 pick_vld, pick_op, gnt_op, grant, burst_done;
    logic [CW-1:0]        pick_ch, gnt_ch;
    logic [LEN_BITS-1:0]  sel_len, len_q;
    logic [ADDR_BITS-1:0] sel_addr, addr_q;
    logic                 rd_req_q, wr_req_q;
    logic [CH_NUM-1:0]    rd_fin_q, wr_fin_q;

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] s);
        return (s == IW'(NSRC - 1)) ? '0 : s + 1'b1;
    endfunction

    // Even source = write, odd source = read of the same channel.
    for (genvar c = 0; c < CH_NUM; c++) begin : g_src
        assign src_req[2*c]   = ch_wr_req[c];
        assign src_req[2*c+1] = ch_rd_req[c];
    end

    rr_pick #(.N(NSRC), .IW(IW)) u_pick (
        .req (src_req),
        .ptr (ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign pick_op  = pick_idx[0];
    assign pick_ch  = CW'(pick_idx >> 1);
    assign sel_len  = (pick_op == OP_RD) ? ch_rd_len[pick_ch*LEN_BITS +: LEN_BITS]
                                         : ch_wr_len[pick_ch*LEN_BITS +: LEN_BITS];
    assign sel_addr = (pick_op == OP_RD) ? ch_rd_addr[pick_ch*ADDR_BITS +: ADDR_BITS]
                                         : ch_wr_addr[pick_ch*ADDR_BITS +: ADDR_BITS];

    assign grant      = (state == ST_IDLE) && init_calib_complete && pick_vld;
    // Only the finish matching the granted operation ends the burst.
    assign burst_done = (state == ST_BUSY) &&
                        (((gnt_op == OP_RD) && mb.rd_burst_finish) ||
                         ((gnt_op == OP_WR) && mb.wr_burst_finish));

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (grant) state_d = (sel_len != '0) ? ST_BUSY : ST_REST;
            ST_BUSY: if (burst_done) state_d = ST_REST;
            ST_REST: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant registers, mem request flops and finish pulses.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            gnt_src  <= '0;
            gnt_ch   <= '0;
            gnt_op   <= OP_WR;
            len_q    <= '0;
            addr_q   <= '0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            rd_fin_q <= '0;
            wr_fin_q <= '0;
        end else begin
            rd_fin_q <= '0;
            wr_fin_q <= '0;
            if (grant) begin
                gnt_src <= pick_idx;
                gnt_ch  <= pick_ch;
                gnt_op  <= pick_op;
                len_q   <= sel_len;
                addr_q  <= sel_addr;
                if (sel_len != '0) begin
                    rd_req_q <= (pick_op == OP_RD);
                    wr_req_q <= (pick_op == OP_WR);
                end else begin
                    // Zero-length: complete locally, mem_burst never sees it.
                    if (pick_op == OP_RD) rd_fin_q[pick_ch] <= 1'b1;
                    else                  wr_fin_q[pick_ch] <= 1'b1;
                    ptr <= ptr_after(pick_idx);
                end
            end
            if (burst_done) begin
                rd_req_q <= 1'b0;
                wr_req_q <= 1'b0;
                if (gnt_op == OP_RD) rd_fin_q[gnt_ch] <= 1'b1;
                else                 wr_fin_q[gnt_ch] <= 1'b1;
                ptr <= ptr_after(gnt_src);
            end
        end
    end

    always_comb begin
        busy             = (state != ST_IDLE);
        ch_wr_data_req   = '0;
        ch_rd_data_valid = '0;
        if (state == ST_BUSY && gnt_op == OP_WR) ch_wr_data_req[gnt_ch]   = mb.wr_burst_data_req;
        if (state == ST_BUSY && gnt_op == OP_RD) ch_rd_data_valid[gnt_ch] = mb.rd_burst_data_valid;
        ch_rd_data       = mb.rd_burst_data;
        mb.wr_burst_data = ch_wr_data[gnt_ch*MEM_DATA_BITS +: MEM_DATA_BITS];
    end

    assign mb.rd_burst_req  = rd_req_q;
    assign mb.wr_burst_req  = wr_req_q;
    assign mb.rd_burst_len  = len_q;
    assign mb.wr_burst_len  = len_q;
    assign mb.rd_burst_addr = addr_q;
    assign mb.wr_burst_addr = addr_q;
    assign ch_rd_finish     = rd_fin_q;
    assign ch_wr_finish     = wr_fin_q;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter: directed bench for mem_burst_arbiter with a simple
// mem_burst responder, a transaction-level reference model checked every
// cycle, and hand-computed expectations for the directed scenarios.
module tb_mem_burst_arbiter;
    import mem_arb_pkg::*;

    localparam int DW = 64;
    localparam int AW = 24;
    localparam int CH = 2;
    localparam int NS = 2 * CH;

    logic              mem_clk = 1'b0;
    logic              rst     = 1'b1;
    logic              calib   = 1'b0;
    logic [CH-1:0]     ch_rd_req = '0, ch_wr_req = '0;
    logic [CH*10-1:0]  ch_rd_len = '0, ch_wr_len = '0;
    logic [CH*AW-1:0]  ch_rd_addr = '0, ch_wr_addr = '0;
    logic [CH*DW-1:0]  ch_wr_data = '0;
    logic [CH-1:0]     ch_wr_data_req, ch_rd_data_valid, ch_rd_finish, ch_wr_finish;
    logic [DW-1:0]     ch_rd_data;
    logic              busy;

    mem_burst_arbiter_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW)) mb ();

    mem_burst_arbiter #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .CH_NUM(CH)) dut (
        .mem_clk             (mem_clk),
        .rst                 (rst),
        .init_calib_complete (calib),
        .ch_rd_req           (ch_rd_req),
        .ch_wr_req           (ch_wr_req),
        .ch_rd_len           (ch_rd_len),
        .ch_wr_len           (ch_wr_len),
        .ch_rd_addr          (ch_rd_addr),
        .ch_wr_addr          (ch_wr_addr),
        .ch_wr_data          (ch_wr_data),
        .ch_wr_data_req      (ch_wr_data_req),
        .ch_rd_data          (ch_rd_data),
        .ch_rd_data_valid    (ch_rd_data_valid),
        .ch_rd_finish        (ch_rd_finish),
        .ch_wr_finish        (ch_wr_finish),
        .busy                (busy),
        .mb                  (mb)
    );

    always #5 mem_clk = ~mem_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (source-level view) ----------------
    // m_phase: 0 idle, 1 burst outstanding at mem_burst, 2 rest cycle
    int              m_phase = 0;
    int              m_src   = -1;
    int              m_ptr   = 0;
    int              m_fin   = -1;
    logic [9:0]      m_len   = '0;
    logic [AW-1:0]   m_addr  = '0;

    function automatic bit src_requesting(input int s);
        return (s % 2 == 1) ? ch_rd_req[s/2] : ch_wr_req[s/2];
    endfunction

    initial begin : model
        forever begin
            @(posedge mem_clk or posedge rst);
            if (rst) begin
                m_phase = 0; m_src = -1; m_ptr = 0; m_fin = -1;
            end else begin
                m_fin = -1;
                if (m_phase == 2) begin
                    m_phase = 0;
                end else if (m_phase == 1) begin
                    if ((m_src % 2 == 1 && mb.rd_burst_finish) ||
                        (m_src % 2 == 0 && mb.wr_burst_finish)) begin
                        m_fin = m_src; m_ptr = (m_src + 1) % NS; m_phase = 2;
                    end
                end else if (calib) begin
                    int pick;
                    pick = -1;
                    for (int k = 0; k < NS; k++)
                        if (pick < 0 && src_requesting((m_ptr + k) % NS)) pick = (m_ptr + k) % NS;
                    if (pick >= 0) begin
                        m_src  = pick;
                        m_len  = (pick % 2 == 1) ? ch_rd_len[(pick/2)*10 +: 10] : ch_wr_len[(pick/2)*10 +: 10];
                        m_addr = (pick % 2 == 1) ? ch_rd_addr[(pick/2)*AW +: AW] : ch_wr_addr[(pick/2)*AW +: AW];
                        if (m_len != 0) m_phase = 1;
                        else begin m_fin = pick; m_ptr = (pick + 1) % NS; m_phase = 2; end
                    end
                end
            end
        end
    end

    initial begin : compare
        logic [CH-1:0] e_wdr, e_rdv, e_rfin, e_wfin;
        bit in_burst, m_rd;
        int mc;
        forever begin
            @(negedge mem_clk);
            if (rst) begin
                chk("reset_outputs", {busy, mb.rd_burst_req, mb.wr_burst_req, ch_rd_finish,
                                      ch_wr_finish, ch_rd_data_valid, ch_wr_data_req}, 64'd0);
            end else begin
                in_burst = (m_phase == 1);
                m_rd     = (m_src % 2 == 1);
                mc       = (m_src < 0) ? 0 : m_src / 2;
                e_wdr = '0; e_rdv = '0; e_rfin = '0; e_wfin = '0;
                if (in_burst && !m_rd && mb.wr_burst_data_req)  e_wdr[mc] = 1'b1;
                if (in_burst &&  m_rd && mb.rd_burst_data_valid) e_rdv[mc] = 1'b1;
                if (m_fin >= 0) begin
                    if (m_fin % 2 == 1) e_rfin[m_fin/2] = 1'b1;
                    else                e_wfin[m_fin/2] = 1'b1;
                end
                chk("busy", busy, m_phase != 0);
                chk("rd_burst_req", mb.rd_burst_req, in_burst && m_rd);
                chk("wr_burst_req", mb.wr_burst_req, in_burst && !m_rd);
                chk("ch_wr_data_req", ch_wr_data_req, e_wdr);
                chk("ch_rd_data_valid", ch_rd_data_valid, e_rdv);
                chk("ch_rd_finish", ch_rd_finish, e_rfin);
                chk("ch_wr_finish", ch_wr_finish, e_wfin);
                chk("ch_rd_data", ch_rd_data, mb.rd_burst_data);
                if (in_burst && m_rd) begin
                    chk("rd_burst_len", mb.rd_burst_len, m_len);
                    chk("rd_burst_addr", mb.rd_burst_addr, m_addr);
                end
                if (in_burst && !m_rd) begin
                    chk("wr_burst_len", mb.wr_burst_len, m_len);
                    chk("wr_burst_addr", mb.wr_burst_addr, m_addr);
                    chk("wr_burst_data", mb.wr_burst_data, ch_wr_data[mc*DW +: DW]);
                end
            end
        end
    end

    // ---------------- mem_burst responder ----------------
    // Sees a request, waits one cycle, gives len strobes back-to-back, then a
    // finish pulse, then one idle cycle.
    initial begin : mem_model
        int ms, mcnt;
        bit mop;
        logic [9:0] mlen;
        ms = 0; mcnt = 0; mop = 1'b0; mlen = '0;
        mb.wr_burst_data_req = 1'b0; mb.rd_burst_data_valid = 1'b0; mb.rd_burst_data = '0;
        mb.rd_burst_finish = 1'b0; mb.wr_burst_finish = 1'b0;
        forever begin
            @(posedge mem_clk);
            #2;
            if (rst) begin
                ms = 0;
                mb.wr_burst_data_req = 1'b0; mb.rd_burst_data_valid = 1'b0;
                mb.rd_burst_finish = 1'b0; mb.wr_burst_finish = 1'b0;
            end else begin
                case (ms)
                    0: if (mb.rd_burst_req || mb.wr_burst_req) begin
                        mop  = mb.rd_burst_req;
                        mlen = mop ? mb.rd_burst_len : mb.wr_burst_len;
                        mcnt = 0;
                        ms   = 1;
                    end
                    1: begin
                        mb.wr_burst_data_req = 1'b0; mb.rd_burst_data_valid = 1'b0;
                        if (mcnt < int'(mlen)) begin
                            if (mop) begin
                                mb.rd_burst_data_valid = 1'b1;
                                mb.rd_burst_data = 64'hD000_0000_0000_0000 + 64'(mcnt);
                            end else mb.wr_burst_data_req = 1'b1;
                            mcnt++;
                        end else begin
                            if (mop) mb.rd_burst_finish = 1'b1;
                            else     mb.wr_burst_finish = 1'b1;
                            ms = 2;
                        end
                    end
                    default: begin
                        mb.rd_burst_finish = 1'b0; mb.wr_burst_finish = 1'b0;
                        ms = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int   cyc = 0;
    int   served[$];
    int   fin_cyc[$];
    int   iss_cyc[$];
    int   wdr_cnt[CH];
    int   rdv_cnt[CH];
    bit   hold[NS];
    logic prev_req = 1'b0;

    task automatic tick();
        @(posedge mem_clk);
        #1;
        cyc++;
        for (int c = 0; c < CH; c++) begin
            if (ch_wr_finish[c]) begin
                served.push_back(2*c); fin_cyc.push_back(cyc);
                if (!hold[2*c]) ch_wr_req[c] = 1'b0;
            end
            if (ch_rd_finish[c]) begin
                served.push_back(2*c+1); fin_cyc.push_back(cyc);
                if (!hold[2*c+1]) ch_rd_req[c] = 1'b0;
            end
            if (ch_wr_data_req[c])   wdr_cnt[c]++;
            if (ch_rd_data_valid[c]) rdv_cnt[c]++;
        end
        if ((mb.rd_burst_req || mb.wr_burst_req) && !prev_req) iss_cyc.push_back(cyc);
        prev_req = mb.rd_burst_req || mb.wr_burst_req;
    endtask

    task automatic clear_log();
        served.delete(); fin_cyc.delete(); iss_cyc.delete();
        for (int c = 0; c < CH; c++) begin wdr_cnt[c] = 0; rdv_cnt[c] = 0; end
    endtask

    task automatic set_src(input int s, input logic [9:0] len, input logic [AW-1:0] addr);
        int c;
        c = s / 2;
        if (s % 2 == 1) begin
            ch_rd_len[c*10 +: 10] = len; ch_rd_addr[c*AW +: AW] = addr; ch_rd_req[c] = 1'b1;
        end else begin
            ch_wr_len[c*10 +: 10] = len; ch_wr_addr[c*AW +: AW] = addr; ch_wr_req[c] = 1'b1;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 500; i++) begin
            if (ch_rd_req == '0 && ch_wr_req == '0 && !busy) break;
            tick();
        end
        chk("drain_timeout", {ch_rd_req, ch_wr_req, busy}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stim
        ch_wr_data = {64'hC1C1_0000_0000_0011, 64'hC0C0_0000_0000_0000};
        for (int s = 0; s < NS; s++) hold[s] = 1'b0;
        clear_log();
        repeat (3) tick();
        chk("rst_busy", busy, 64'd0);
        chk("rst_mem_req", {mb.rd_burst_req, mb.wr_burst_req}, 64'd0);
        chk("rst_finish", {ch_rd_finish, ch_wr_finish}, 64'd0);
        rst = 1'b0; calib = 1'b1;
        tick(); tick();

        // ch0 write, len 4 @ 0x100: request one cycle after ch_wr_req.
        clear_log();
        set_src(0, 10'd4, 24'h100);
        chk("t1_req_before", mb.wr_burst_req, 64'd0);
        tick();
        chk("t1_req_latency", mb.wr_burst_req, 64'd1);
        chk("t1_rd_req", mb.rd_burst_req, 64'd0);
        chk("t1_addr", mb.wr_burst_addr, 64'h100);
        chk("t1_len", mb.wr_burst_len, 64'd4);
        wait_done();
        chk("t1_ch0_strobes", wdr_cnt[0], 64'd4);
        chk("t1_ch1_strobes", wdr_cnt[1], 64'd0);
        chk("t1_finish_count", served.size(), 64'd1);
        chk("t1_finish_src", (served.size() > 0) ? served[0] : -1, 64'd0);

        // All four sources from reset, len 2 each: order 0,1,2,3, one REST apart.
        do_reset();
        clear_log();
        for (int s = 0; s < NS; s++) set_src(s, 10'd2, 24'h200 + 24'(s * 16));
        wait_done();
        chk("t2_count", served.size(), 64'd4);
        for (int i = 0; i < 4 && i < served.size(); i++) chk("t2_order", served[i], i);
        chk("t2_issue_count", iss_cyc.size(), 64'd4);
        for (int i = 0; i < 3 && i + 1 < iss_cyc.size() && i < fin_cyc.size(); i++)
            chk("t2_rest_gap", iss_cyc[i+1] - fin_cyc[i], 64'd2);

        // ch0 write re-requesting vs ch1 read held: strict alternation.
        clear_log();
        hold[0] = 1'b1; hold[3] = 1'b1;
        set_src(0, 10'd3, 24'h300);
        set_src(3, 10'd3, 24'h380);
        for (int i = 0; i < 1000 && served.size() < 10; i++) tick();
        hold[0] = 1'b0; hold[3] = 1'b0;
        ch_wr_req[0] = 1'b0; ch_rd_req[1] = 1'b0;
        wait_done();
        chk("t3_count", served.size(), 64'd10);
        for (int i = 0; i < 10 && i < served.size(); i++)
            chk("t3_alternate", served[i], (i % 2 == 0) ? 0 : 3);

        // ch0 read len 0: no mem request, finish next cycle, ptr -> 2.
        clear_log();
        set_src(1, 10'd0, 24'h400);
        tick();
        chk("t4_rd_finish", ch_rd_finish, 64'd1);
        chk("t4_no_rd_req", mb.rd_burst_req, 64'd0);
        chk("t4_busy", busy, 64'd1);
        wait_done();
        clear_log();
        set_src(0, 10'd1, 24'h410);
        set_src(2, 10'd1, 24'h420);
        wait_done();
        chk("t4_ptr_count", served.size(), 64'd2);
        chk("t4_ptr_first", (served.size() > 0) ? served[0] : -1, 64'd2);
        chk("t4_ptr_second", (served.size() > 1) ? served[1] : -1, 64'd0);

        // Calibration gate; calib dropping mid-burst does not abort it.
        clear_log();
        calib = 1'b0;
        set_src(2, 10'd2, 24'h500);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_gated_req", mb.wr_burst_req, 64'd0);
            chk("t5_gated_busy", busy, 64'd0);
        end
        calib = 1'b1;
        tick();
        chk("t5_grant", mb.wr_burst_req, 64'd1);
        chk("t5_addr", mb.wr_burst_addr, 64'h500);
        calib = 1'b0;
        wait_done();
        chk("t5_finished", served.size(), 64'd1);
        calib = 1'b1;

        // Reset mid-read at data word 3 of 8; ptr restarts at 0.
        clear_log();
        set_src(1, 10'd2, 24'h580);
        wait_done();
        clear_log();
        set_src(3, 10'd8, 24'h600);
        for (int i = 0; i < 100 && rdv_cnt[1] < 3; i++) tick();
        chk("t6_word3", rdv_cnt[1], 64'd3);
        rst = 1'b1;
        #1;
        chk("t6_rst_rd_req", mb.rd_burst_req, 64'd0);
        chk("t6_rst_busy", busy, 64'd0);
        chk("t6_rst_finish", {ch_rd_finish, ch_wr_finish}, 64'd0);
        chk("t6_rst_valid", ch_rd_data_valid, 64'd0);
        ch_rd_req = '0; ch_wr_req = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        clear_log();
        set_src(0, 10'd1, 24'h700);
        set_src(2, 10'd1, 24'h720);
        wait_done();
        chk("t6_ptr_count", served.size(), 64'd2);
        chk("t6_ptr_first", (served.size() > 0) ? served[0] : -1, 64'd0);
        chk("t6_ptr_second", (served.size() > 1) ? served[1] : -1, 64'd2);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Shares the single mem_burst read/write burst port between CH_NUM requester channels, for example a video writer, a video reader and a test generator.
- Each channel has an independent read request and write request.
- Sources are served one burst at a time, in round-robin order.
- Routes burst addresses, lengths and write data to mem_burst; routes read data, data strobes and finish pulses back to the granted channel only.

Parameters:
- MEM_DATA_BITS, 64, burst data width.
- ADDR_BITS, 24, burst address width, in burst-word units.
- CH_NUM, 2, number of channels, legal range 1..4.

Ports:
- mem_clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- init_calib_complete  in  1  DDR calibration done; no grant is issued while low.
- ch_rd_req  in  CH_NUM  per-channel read request; level, held until ch_rd_finish.
- ch_wr_req  in  CH_NUM  per-channel write request; level, held until ch_wr_finish.
- ch_rd_len  in  CH_NUM*10  read length in words; channel i occupies bits [10i+9:10i].
- ch_wr_len  in  CH_NUM*10  write length in words, same packing.
- ch_rd_addr  in  CH_NUM*ADDR_BITS  read start address.
- ch_wr_addr  in  CH_NUM*ADDR_BITS  write start address.
- ch_wr_data  in  CH_NUM*MEM_DATA_BITS  write data, per channel.
- ch_wr_data_req  out  CH_NUM  write-data request, routed to the granted channel only.
- ch_rd_data  out  MEM_DATA_BITS  read data, shared bus.
- ch_rd_data_valid  out  CH_NUM  read-data valid, granted channel only.
- ch_rd_finish  out  CH_NUM  one-cycle pulse: read burst done.
- ch_wr_finish  out  CH_NUM  one-cycle pulse: write burst done.
- busy  out  1  arbiter not in IDLE.
- rd_burst_req, wr_burst_req  out  1  requests to mem_burst.
- rd_burst_len, wr_burst_len  out  10  lengths to mem_burst.
- rd_burst_addr, wr_burst_addr  out  ADDR_BITS  addresses to mem_burst.
- wr_burst_data  out  MEM_DATA_BITS  write data to mem_burst.
- wr_burst_data_req  in  1  write-data request from mem_burst.
- rd_burst_data  in  MEM_DATA_BITS  read data from mem_burst.
- rd_burst_data_valid  in  1  read-data valid from mem_burst.
- rd_burst_finish, wr_burst_finish  in  1  burst-done pulses from mem_burst.

Behaviour:
- Source numbering: source index s = 2*ch + op, where op 0 = write and op 1 = read. There are 2*CH_NUM sources.
- Round-robin pointer ptr: the search starts at ptr. After a source is served, ptr becomes (served index + 1) mod 2*CH_NUM. Reset value is 0.
- State machine: IDLE, BUSY, REST.
- IDLE:
  - If init_calib_complete is high and any source is requesting, pick the first requesting source from ptr upward, wrapping.
  - Latch gnt_idx, gnt_op and the mux-selected len and addr into registers.
  - Selected len != 0: next cycle, assert rd_burst_req or wr_burst_req with registered len/addr; go to BUSY. Latency from request seen to mem request is 1 cycle.
  - Selected len == 0: do not issue to mem_burst; pulse the channel finish next cycle, update ptr, go to REST.
- BUSY:
  - Hold the mem request and len/addr stable.
  - On rd_burst_finish or wr_burst_finish: deassert the mem request registers in the same edge; pulse ch_*_finish[gnt_idx] for 1 cycle; update ptr; go to REST.
  - A finish pulse of the wrong type is ignored.
- REST: one cycle, then IDLE. This guarantees the mem request is low when mem_burst returns to its IDLE and samples requests.
- Data routing, combinational:
  - wr_burst_data = ch_wr_data slice for gnt_idx.
  - ch_wr_data_req[gnt_idx] = wr_burst_data_req when in BUSY and gnt_op = write; all other bits 0.
  - ch_rd_data = rd_burst_data.
  - ch_rd_data_valid[gnt_idx] = rd_burst_data_valid when in BUSY and gnt_op = read; all other bits 0.
- Requests sampled only in IDLE. A channel dropping its request after grant does not abort the burst; the burst completes and finish still pulses.
- Simultaneous read and write requests from one channel are served as two separate sources, in round-robin order.
- init_calib_complete falling mid-burst: the arbiter stays in BUSY and waits for finish.
- Reset values: all outputs 0, state IDLE, ptr 0. An async reset mid-burst drops all requests immediately; recovery of mem_burst is the system's job, since it shares rst.

Decomposition:
- Shared package mem_arb_pkg:
  - state encodings (IDLE, BUSY, REST);
  - OP_WR = 0, OP_RD = 1;
  - LEN_BITS = 10.
- One sub-module, rr_pick: combinational round-robin selector with a 2*CH_NUM request vector and pointer in, and a valid flag plus index out.

Test Plan:
- ch0 write len 4, addr 0x100 → wr_burst_req high 1 cycle after ch_wr_req[0]; wr_burst_addr = 0x100, len = 4; 4 ch_wr_data_req[0] strobes; ch_wr_finish[0] pulses once; ch1 strobes stay 0.
- All 4 sources request from reset, each len 2 → service order: s0 (ch0 wr), s1 (ch0 rd), s2 (ch1 wr), s3 (ch1 rd); exactly one REST cycle between bursts.
- ch1 read held continuously while ch0 write re-requests after each finish → strict alternation, with neither source starved over 10 bursts.
- ch0 read len 0 → no rd_burst_req; ch_rd_finish[0] pulses 1 cycle after grant; ptr advances to 2.
- init_calib_complete low with requests pending → no mem request issued; the grant follows 1 cycle after calib goes high.
- rst asserted mid-read at data word 3 of 8 → rd_burst_req, busy and all finish outputs 0 asynchronously; ptr = 0 after release.
